apb2axi_axi_wr_responder: RTL and testbench
===========================================

// Module: apb2axi_axi_wr_responder
// PURPOSE
// - AXI write-side slave: accepts AW + W bursts, stores data in an internal word memory, returns one B response per burst.
// - Far-end counterpart of the APB2AXI write path; acts as the downstream target in block and system simulation.
// - Includes a combinational debug read port so benches can check memory contents.
// PARAMETERS
// - AXI_ADDR_W   32   address width
// - AXI_DATA_W   64   data width; ADDR_LSB = $clog2(AXI_DATA_W/8)
// - AXI_ID_W     4    ID width
// - MEM_DEPTH    256  memory depth in AXI_DATA_W words
// - BRESP_DELAY  4    extra B latency in cycles; used only when APB2AXI_WRESP_DELAY_EN is defined
// PORTS
// - aclk        in   1                  clock
// - aresetn     in   1                  reset; synchronous, active-low
// - awid        in   AXI_ID_W           write ID
// - awaddr      in   AXI_ADDR_W         byte address
// - awlen       in   4                  beats-1
// - awsize      in   3                  beat size
// - awburst     in   2                  00 FIXED, 01 INCR
// - awvalid     in   1                  AW valid
// - awready     out  1                  AW ready
// - wdata       in   AXI_DATA_W         write data
// - wstrb       in   AXI_DATA_W/8       byte strobes
// - wlast       in   1                  last beat
// - wvalid      in   1                  W valid
// - wready      out  1                  W ready
// - bid         out  AXI_ID_W           response ID
// - bresp       out  2                  00 OKAY, 10 SLVERR
// - bvalid      out  1                  B valid
// - bready      in   1                  B ready
// - dbg_idx     in   $clog2(MEM_DEPTH)  debug word index
// - dbg_rdata   out  AXI_DATA_W         mem[dbg_idx], combinational
// BEHAVIOUR
// - Reset: while aresetn=0, awready=wready=bvalid=0, bid=0, bresp=00. State goes to IDLE; error flag and beat counter clear. Memory is not reset.
// - Reset mid-burst aborts the burst. No B is issued for it. Beats already written stay written.
// - FSM: IDLE (awready=1) -> DATA (wready=1) -> [WAIT] -> RESP (bvalid=1) -> IDLE. Only one burst is outstanding at a time.
// - IDLE: on awvalid&&awready, latch awid, idx = awaddr>>ADDR_LSB (low bits ignored), awlen, and burst type. Clear beat counter and error flag. Next state is DATA, so wready is 1 from the next cycle.
// - W is never accepted in IDLE, WAIT or RESP. AW is never accepted outside IDLE.
// - Burst-level error (SLVERR, no write on any beat of the burst):
//   - awsize != ADDR_LSB, or
//   - awburst is 10 or 11.
// - DATA, each wvalid&&wready:
//   - If idx < MEM_DEPTH and no burst-level error: write mem[idx] bytes where wstrb=1; other bytes keep their old value.
//   - If idx >= MEM_DEPTH: no write, set error.
//   - INCR: idx+1 after each beat; idx does not wrap, so going past the end causes errors. FIXED: idx unchanged.
// - Burst ends after exactly awlen+1 W handshakes, whatever wlast says.
//   - wlast=1 before the final beat, or wlast=0 on the final beat, sets error.
//   - All awlen+1 beats are still consumed.
// - Final W handshake in cycle M: bvalid=1 from M+1, with bid = latched awid and bresp = 10 if error else 00.
// - RESP: bvalid, bid and bresp stay stable until bready. On handshake, go to IDLE; awready=1 the next cycle.
// - Back-to-back: minimum of 1 IDLE cycle between bursts.
// - Error flag is sticky for the burst and clears on the next AW handshake.
// CONFIGURATION
// - APB2AXI_WRESP_DELAY_EN defined:
//   - After the final W handshake, the FSM enters WAIT and counts BRESP_DELAY cycles.
//   - bvalid rises in cycle M+1+BRESP_DELAY. BRESP_DELAY=0 behaves as undefined.
// - APB2AXI_WRESP_DELAY_EN undefined: WAIT state and counter are not built; bvalid rises in M+1.
// TESTING
// - Single beat: awid=3, awaddr=0x10, awlen=0, awsize=3, INCR, wdata=0xDEADBEEF_CAFEF00D, wstrb=0xFF, wlast=1 -> mem[2]=that data; bvalid at M+1 with bid=3, bresp=00.
// - 4-beat INCR at 0x0: wstrb=0x0F on beat 2 over old value 0x1111_1111_1111_1111, wdata=0xAAAA_AAAA_BBBB_BBBB -> mem[2]=0x1111_1111_BBBB_BBBB; mem[0,1,3] are full words; bresp=00.
// - Out of range: awaddr=MEM_DEPTH*8, awlen=1 -> 2 beats accepted, memory unchanged, bresp=10.
// - Back-pressure: bready=0 for 5 cycles after bvalid -> bvalid, bid and bresp stay stable; awready=0 and wready=0 throughout; awready=1 the cycle after the handshake.
// - Protocol error: awlen=2 with wlast=1 on beat 1 -> 3 beats still consumed, bresp=10. Separately, awsize=2 -> no write, bresp=10.
// - Reset mid-burst: aresetn=0 after beat 1 of 4 -> outputs at reset values, no B issued; a following 1-beat burst completes with bresp=00.

Source files
------------

// File: rtl/apb2axi_axi_wr_responder.sv
// ----------------------------------------------------------------------------
// apb2axi_axi_wr_responder
//
// AXI write-side slave used as the far-end target of the APB2AXI write path.
// Accepts one AW + W burst at a time, stores beats into an internal word
// memory (byte-strobed) and returns a single B response per burst. A
// combinational debug port exposes memory contents.
//
// Optional feature macro: APB2AXI_WRESP_DELAY_EN
//   defined   : after the final W beat the FSM waits BRESP_DELAY cycles in
//               WAIT before raising bvalid (BRESP_DELAY=0 skips WAIT).
//   undefined : WAIT state and its counter are not built; bvalid rises the
//               cycle after the final W handshake.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   aw*                  write address channel (awready high only in IDLE)
//   w*                   write data channel (wready high only in DATA)
//   bid, bresp, bvalid,  write response channel (OKAY=00, SLVERR=10)
//   bready
//   dbg_idx, dbg_rdata   debug word index / mem[dbg_idx] (combinational)
// ----------------------------------------------------------------------------
module apb2axi_axi_wr_responder #(
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_ID_W    = 4,
    parameter int MEM_DEPTH   = 256,
    parameter int BRESP_DELAY = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXI_ID_W-1:0]           awid,
    input  logic [AXI_ADDR_W-1:0]         awaddr,
    input  logic [3:0]                    awlen,
    input  logic [2:0]                    awsize,
    input  logic [1:0]                    awburst,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [AXI_DATA_W-1:0]         wdata,
    input  logic [AXI_DATA_W/8-1:0]       wstrb,
    input  logic                          wlast,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [AXI_ID_W-1:0]           bid,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_idx,
    output logic [AXI_DATA_W-1:0]         dbg_rdata
);

    localparam int ADDR_LSB = $clog2(AXI_DATA_W/8);
    localparam int STRB_W   = AXI_DATA_W/8;
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam int WIDX_W   = AXI_ADDR_W - ADDR_LSB;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_RESP = 2'd3;
`ifdef APB2AXI_WRESP_DELAY_EN
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam int         DLY_W  = (BRESP_DELAY > 0) ? $clog2(BRESP_DELAY + 1) : 1;
`endif

    logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

    logic [1:0]            state, state_nxt;
    logic                  awready_q, wready_q, bvalid_q;
    logic [AXI_ID_W-1:0]   bid_q;
    logic [1:0]            bresp_q;

    // Burst context latched on the AW handshake
    logic [AXI_ID_W-1:0]   id_q;
    logic [WIDX_W-1:0]     idx_q;
    logic [3:0]            len_q;
    logic                  fixed_q;
    logic                  burst_err_q;   // blocks every write of the burst
    logic                  err_q;         // sticky SLVERR for the burst
    logic [3:0]            beat_cnt;

    logic                  aw_hs, w_hs, last_beat, in_range, aw_bad;
    logic                  beat_err, err_nxt, wr_en;
    logic [IDX_W-1:0]      mem_idx;

    // Address LSBs below the word size carry no information here.
    logic                  unused_lsb;
    assign unused_lsb = ^awaddr[ADDR_LSB-1:0];

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bid       = bid_q;
    assign bresp     = bresp_q;

    assign aw_hs     = awvalid && awready_q;
    assign w_hs      = wvalid && wready_q;
    assign last_beat = (beat_cnt == len_q);
    assign in_range  = (idx_q < WIDX_W'(MEM_DEPTH));
    assign mem_idx   = idx_q[IDX_W-1:0];
    assign aw_bad    = (awsize != 3'(ADDR_LSB)) || awburst[1];

    // A wlast that disagrees with the beat count is an error, but the burst
    // length is still governed by awlen alone.
    assign beat_err  = !in_range || (wlast != last_beat);
    assign err_nxt   = err_q || (w_hs && beat_err);
    assign wr_en     = aresetn && w_hs && in_range && !burst_err_q;

`ifdef APB2AXI_WRESP_DELAY_EN
    logic [DLY_W-1:0] dly_cnt;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (aw_hs) state_nxt = S_DATA;
            S_DATA: begin
                if (w_hs && last_beat) begin
`ifdef APB2AXI_WRESP_DELAY_EN
                    state_nxt = (BRESP_DELAY == 0) ? S_RESP : S_WAIT;
`else
                    state_nxt = S_RESP;
`endif
                end
            end
`ifdef APB2AXI_WRESP_DELAY_EN
            S_WAIT: if (dly_cnt == '0) state_nxt = S_RESP;
`endif
            S_RESP: if (bready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they are clean
    // flops and read zero once reset has been sampled.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= S_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= 2'b00;
            err_q       <= 1'b0;
            burst_err_q <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            awready_q <= (state_nxt == S_IDLE);
            wready_q  <= (state_nxt == S_DATA);
            bvalid_q  <= (state_nxt == S_RESP);

            if (aw_hs) begin
                id_q        <= awid;
                idx_q       <= awaddr[AXI_ADDR_W-1:ADDR_LSB];
                len_q       <= awlen;
                fixed_q     <= (awburst == 2'b00);
                burst_err_q <= aw_bad;
                err_q       <= aw_bad;
                beat_cnt    <= '0;
            end

            if (w_hs) begin
                beat_cnt <= beat_cnt + 4'd1;
                err_q    <= err_nxt;
                // Saturate rather than wrap so a runaway INCR stays out of range.
                if (!fixed_q && (idx_q != '1))
                    idx_q <= idx_q + WIDX_W'(1);
            end

            if ((state_nxt == S_RESP) && (state != S_RESP)) begin
                bid_q   <= id_q;
                bresp_q <= err_nxt ? 2'b10 : 2'b00;
            end
        end
    end

`ifdef APB2AXI_WRESP_DELAY_EN
    always_ff @(posedge aclk) begin
        if (!aresetn)
            dly_cnt <= '0;
        else if (w_hs && last_beat)
            dly_cnt <= DLY_W'(BRESP_DELAY - 1);
        else if ((state == S_WAIT) && (dly_cnt != '0))
            dly_cnt <= dly_cnt - DLY_W'(1);
    end
`else
    localparam int UNUSED_BRESP_DELAY = BRESP_DELAY;
`endif

    // Memory is deliberately not reset; only strobed bytes are updated.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b])
                    mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign dbg_rdata = mem[dbg_idx];

endmodule

// File: tb/tb_apb2axi_axi_wr_responder.sv
module tb_apb2axi_axi_wr_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  dbg_idx;
    logic [63:0] dbg_rdata;

`ifdef APB2AXI_WRESP_DELAY_EN
    localparam int DLY = 4;
`else
    localparam int DLY = 0;
`endif

    apb2axi_axi_wr_responder dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_idx(dbg_idx), .dbg_rdata(dbg_rdata)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] bdata [16];
    logic [7:0]  bstrb [16];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endfunction

    // B-channel monitor: pops the scoreboard on each bvalid rise.
    logic       bv_prev = 1'b0;
    logic [3:0] hold_id;
    logic [1:0] hold_resp;
    always @(negedge aclk) begin
        exp_t e;
        if (aresetn && bvalid && !bv_prev) begin
            if (sb.size() == 0) begin
                timeout("unexpected_b");
            end else begin
                e = sb.pop_front();
                chk("b_id", 64'(bid), 64'(e.id));
                chk("b_resp", 64'(bresp), 64'(e.resp));
                chk("b_cycle", 64'(cyc), 64'(e.cyc));
                chk("b_no_aw_w_ready", {62'd0, awready, wready}, 64'd0);
            end
            hold_id   = bid;
            hold_resp = bresp;
        end else if (bvalid && bready) begin
            chk("b_stable_id", 64'(bid), 64'(hold_id));
            chk("b_stable_resp", 64'(bresp), 64'(hold_resp));
        end
        bv_prev = bvalid;
    end

    task automatic mem_chk(input string name, input int idx, input logic [63:0] exp);
        dbg_idx = 8'(idx);
        #1;
        chk(name, dbg_rdata, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, 64'(awready), 64'd0);
        chk({tag, "_wready"}, 64'(wready), 64'd0);
        chk({tag, "_bvalid"}, 64'(bvalid), 64'd0);
        chk({tag, "_bid"}, 64'(bid), 64'd0);
        chk({tag, "_bresp"}, 64'(bresp), 64'd0);
    endtask

    // Called at a negedge; returns at a negedge. wl_bad flips wlast on that
    // beat; abort_after >= 0 resets the DUT after that beat's handshake.
    task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] bt, input int wl_bad,
                         input int abort_after, input logic [1:0] exp_resp);
        int   t;
        exp_t e;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = bt; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 100) begin @(negedge aclk); t++; end
        if (!awready) begin timeout("aw_handshake"); awvalid = 1'b0; return; end
        @(negedge aclk);
        awvalid = 1'b0;
        chk("wready_after_aw", 64'(wready), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            wdata = bdata[b]; wstrb = bstrb[b];
            wlast = (b == int'(len)) ^ (b == wl_bad);
            wvalid = 1'b1;
            t = 0;
            while (!wready && t < 100) begin @(negedge aclk); t++; end
            if (!wready) begin timeout("w_handshake"); wvalid = 1'b0; return; end
            if (b == int'(len)) begin
                e.id = id; e.resp = exp_resp; e.cyc = cyc + 1 + DLY;
                sb.push_back(e);
            end
            @(negedge aclk);
            wvalid = 1'b0; wlast = 1'b0;
            if (b == abort_after) begin
                aresetn = 1'b0;
                @(negedge aclk);
                chk_reset_outputs("midrst");
                @(negedge aclk);
                aresetn = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_b_done();
        int t = 0;
        while ((sb.size() != 0 || bvalid) && t < 100) begin @(negedge aclk); t++; end
        if (t >= 100) timeout("b_complete");
        @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        aresetn = 1'b0; bready = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; dbg_idx = '0;
        for (int i = 0; i < 16; i++) begin bdata[i] = '0; bstrb[i] = 8'hFF; end
        repeat (3) @(negedge aclk);
        chk_reset_outputs("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        // Single beat
        bdata[0] = 64'hDEADBEEF_CAFEF00D; bstrb[0] = 8'hFF;
        burst(4'd3, 32'h10, 4'd0, 3'd3, 2'b01, -1, -1, 2'b00);
        wait_b_done();
        mem_chk("single_mem2", 2, 64'hDEADBEEF_CAFEF00D);

        // Old value, then 4-beat INCR with a partial strobe on beat 2
        bdata[0] = 64'h1111_1111_1111_1111;
        burst(4'd1, 32'h10, 4'd0, 3'd3, 2'b01, -1, -1, 2'b00);
        wait_b_done();
        bdata[0] = 64'h0101_0101_0101_0101; bstrb[0] = 8'hFF;
        bdata[1] = 64'h0202_0202_0202_0202; bstrb[1] = 8'hFF;
        bdata[2] = 64'hAAAA_AAAA_BBBB_BBBB; bstrb[2] = 8'h0F;
        bdata[3] = 64'h0404_0404_0404_0404; bstrb[3] = 8'hFF;
        burst(4'd5, 32'h0, 4'd3, 3'd3, 2'b01, -1, -1, 2'b00);
        wait_b_done();
        mem_chk("incr_mem0", 0, 64'h0101_0101_0101_0101);
        mem_chk("incr_mem1", 1, 64'h0202_0202_0202_0202);
        mem_chk("incr_mem2_strb", 2, 64'h1111_1111_BBBB_BBBB);
        mem_chk("incr_mem3", 3, 64'h0404_0404_0404_0404);
        for (int i = 0; i < 16; i++) bstrb[i] = 8'hFF;

        // Out of range: idx 256 aliases to 0 in the low bits; nothing may change
        bdata[0] = 64'h9999_9999_9999_9999; bdata[1] = 64'h8888_8888_8888_8888;
        burst(4'd2, 32'h800, 4'd1, 3'd3, 2'b01, -1, -1, 2'b10);
        wait_b_done();
        mem_chk("oor_mem0", 0, 64'h0101_0101_0101_0101);
        mem_chk("oor_mem1", 1, 64'h0202_0202_0202_0202);

        // Back-pressure on B
        bready = 1'b0;
        bdata[0] = 64'h4444_4444_4444_4444;
        burst(4'd7, 32'h20, 4'd0, 3'd3, 2'b01, -1, -1, 2'b00);
        t = 0;
        while (!bvalid && t < 50) begin @(negedge aclk); t++; end
        if (!bvalid) timeout("bp_bvalid");
        repeat (5) begin
            @(negedge aclk);
            chk("bp_hold", {61'd0, bvalid, awready, wready}, 64'h4);
        end
        bready = 1'b1;
        @(negedge aclk);
        chk("bp_awready_after", {62'd0, awready, bvalid}, 64'h2);
        mem_chk("bp_mem4", 4, 64'h4444_4444_4444_4444);

        // Early wlast on beat 1 of 3: still 3 beats, all written, SLVERR
        bdata[0] = 64'h5555_5555_5555_5555; bdata[1] = 64'h6666_6666_6666_6666;
        bdata[2] = 64'h7777_7777_7777_7777;
        burst(4'd4, 32'h40, 4'd2, 3'd3, 2'b01, 1, -1, 2'b10);
        wait_b_done();
        mem_chk("early_last_mem9", 9, 64'h6666_6666_6666_6666);
        mem_chk("early_last_mem10", 10, 64'h7777_7777_7777_7777);

        // Missing wlast on the final beat
        burst(4'd6, 32'h60, 4'd1, 3'd3, 2'b01, 1, -1, 2'b10);
        wait_b_done();
        mem_chk("no_last_mem13", 13, 64'h6666_6666_6666_6666);

        // Wrong awsize: no write
        bdata[0] = 64'hEEEE_EEEE_EEEE_EEEE;
        burst(4'd8, 32'h18, 4'd0, 3'd2, 2'b01, -1, -1, 2'b10);
        wait_b_done();
        mem_chk("size_err_mem3", 3, 64'h0404_0404_0404_0404);

        // Reserved burst type: no write
        burst(4'd11, 32'h0, 4'd0, 3'd3, 2'b10, -1, -1, 2'b10);
        wait_b_done();
        mem_chk("burst_err_mem0", 0, 64'h0101_0101_0101_0101);

        // FIXED: every beat lands on the same word
        bdata[0] = 64'hC1C1_C1C1_C1C1_C1C1; bdata[1] = 64'hC2C2_C2C2_C2C2_C2C2;
        bdata[2] = 64'hC3C3_C3C3_C3C3_C3C3;
        bdata[3] = 64'h0;
        burst(4'd12, 32'h28, 4'd2, 3'd3, 2'b00, -1, -1, 2'b00);
        wait_b_done();
        mem_chk("fixed_mem5", 5, 64'hC3C3_C3C3_C3C3_C3C3);

        // INCR running off the last word
        bdata[0] = 64'hB1B1_B1B1_B1B1_B1B1; bdata[1] = 64'hB2B2_B2B2_B2B2_B2B2;
        burst(4'd13, 32'h7F8, 4'd1, 3'd3, 2'b01, -1, -1, 2'b10);
        wait_b_done();
        mem_chk("edge_mem255", 255, 64'hB1B1_B1B1_B1B1_B1B1);
        mem_chk("edge_mem0", 0, 64'h0101_0101_0101_0101);

        // Reset after beat 1 of 4: no B, written beat kept, next burst clean
        bdata[0] = 64'hF0F0_F0F0_F0F0_F0F0;
        burst(4'd9, 32'h80, 4'd3, 3'd3, 2'b01, -1, 0, 2'b00);
        mem_chk("rst_mem16", 16, 64'hF0F0_F0F0_F0F0_F0F0);
        bdata[0] = 64'h1717_1717_1717_1717;
        burst(4'd10, 32'h88, 4'd0, 3'd3, 2'b01, -1, -1, 2'b00);
        wait_b_done();
        mem_chk("rst_next_mem17", 17, 64'h1717_1717_1717_1717);

        repeat (5) @(negedge aclk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
